// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_ctrl_pkg;

  // Frame tracking state: waiting for a start edge, or inside a frame.
  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  // Oversampling ratio applied after reset.
  localparam int PRESCALE_RST     = 8;
  // Start + 8 data + stop bits; one more when parity is enabled.
  localparam int FRAME_BITS_NOPAR = 10;
  // Saturation value of the error counter.
  localparam int ERR_CNT_MAX      = 255;
  // Width of the in-frame cycle counter and the timeout arithmetic.
  localparam int FRAME_CNT_WIDTH  = 10;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive buffer. The head entry is presented
// combinationally; the caller guarantees push only when not full (or
// popping in the same cycle) and pop only when out_valid.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  full
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW:0]           count_reg;

  // Storage write; contents need no reset because emptiness masks them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of 2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == DEPTH_CNT);
  // Drive zero when empty so the output is clean out of reset.
  assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: tracks frames on the serial line, applies
// configuration only between frames, buffers good words and counts errors.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      rx_clk,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic                      cfg_parity_enable,
  input  logic                      cfg_parity_type,
  input  logic                      rx_in,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      stop_error,
  input  logic                      parity_error,
  output logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      parity_enable,
  output logic                      parity_type,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic [7:0]                err_cnt,
  input  logic                      cnt_clr,
  output logic                      busy
);

  state_t                      state_reg, state_next;
  logic [FRAME_CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [FRAME_CNT_WIDTH-1:0]  ps_ext, frame_bits, timeout_lim;
  logic                        rx_q_reg;
  logic                        pending_reg;
  logic [PRESCALE_WIDTH-1:0]   pend_prescale_reg;
  logic                        pend_parity_enable_reg;
  logic                        pend_parity_type_reg;
  logic [PRESCALE_WIDTH-1:0]   prescale_reg;
  logic                        parity_enable_reg;
  logic                        parity_type_reg;
  logic                        overflow_reg;
  logic [7:0]                  err_cnt_reg;
  logic                        fifo_full, fifo_push, fifo_pop;
  logic                        apply_cfg, err_event;

  // Timeout is one prescale period past the last expected bit.
  assign ps_ext      = FRAME_CNT_WIDTH'(prescale_reg);
  assign frame_bits  = FRAME_CNT_WIDTH'(FRAME_BITS_NOPAR) + FRAME_CNT_WIDTH'(parity_enable_reg);
  assign timeout_lim = frame_bits * ps_ext + ps_ext - 1'b1;

  assign apply_cfg = (state_reg == IDLE) && pending_reg;
  assign err_event = stop_error | parity_error;
  assign fifo_pop  = out_valid && out_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign fifo_push = data_valid && (!fifo_full || fifo_pop);

  // Frame state register and in-frame cycle counter.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rx_q_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rx_q_reg  <= rx_in;
    end
  end

  // Next-state: enter on a falling edge, leave on any core verdict or timeout.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_q_reg && !rx_in) state_next = FRAME;
      end
      FRAME: begin
        if (data_valid || stop_error || parity_error || (cnt_reg == timeout_lim)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pending/applied configuration; a new write wins over a same-cycle apply.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      pending_reg            <= 1'b0;
      pend_prescale_reg      <= PRESCALE_WIDTH'(PRESCALE_RST);
      pend_parity_enable_reg <= 1'b0;
      pend_parity_type_reg   <= 1'b0;
      prescale_reg           <= PRESCALE_WIDTH'(PRESCALE_RST);
      parity_enable_reg      <= 1'b0;
      parity_type_reg        <= 1'b0;
    end else begin
      if (apply_cfg) begin
        prescale_reg      <= pend_prescale_reg;
        parity_enable_reg <= pend_parity_enable_reg;
        parity_type_reg   <= pend_parity_type_reg;
      end
      if (cfg_wr) begin
        pending_reg            <= 1'b1;
        pend_prescale_reg      <= cfg_prescale;
        pend_parity_enable_reg <= cfg_parity_enable;
        pend_parity_type_reg   <= cfg_parity_type;
      end else if (apply_cfg) begin
        pending_reg <= 1'b0;
      end
    end
  end

  // Sticky overflow and saturating error counter; clears take priority.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      if (ovf_clr)                        overflow_reg <= 1'b0;
      else if (data_valid && !fifo_push)  overflow_reg <= 1'b1;
      if (cnt_clr)                        err_cnt_reg <= '0;
      else if (err_event && (err_cnt_reg != 8'(ERR_CNT_MAX)))
                                          err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  uart_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (rx_clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (p_data),
    .pop       (fifo_pop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .full      (fifo_full)
  );

  assign prescale      = prescale_reg;
  assign parity_enable = parity_enable_reg;
  assign parity_type   = parity_type_reg;
  assign overflow      = overflow_reg;
  assign err_cnt       = err_cnt_reg;
  assign busy          = (state_reg == FRAME);

endmodule
